// File: rtl/divu4_sequential_pkg.sv
// Shared definitions for the sequential unsigned divider: default width and FSM state encoding.
package divu4_sequential_pkg;

  localparam int DIVU_WIDTH = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/divu4_sequential_addsubn_unit.sv
// N-bit combinational adder/subtractor; subtract inverts b so carry_in=1 forms two's complement.
module addsubn_unit #(
  parameter int N = 5
) (
  input  logic         subtract,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         carry_in,
  output logic [N-1:0] result,
  output logic         carry_out
);

  logic [N-1:0] b_eff;

  assign b_eff = b ^ {N{subtract}};
  assign {carry_out, result} = {1'b0, a} + {1'b0, b_eff} + {{N{1'b0}}, carry_in};

endmodule

// File: rtl/divu4_sequential.sv
// Multi-cycle restoring divider: one trial subtraction per clock, result after WIDTH iterations.
// state   | meaning
// IDLE    | waiting for start; results held
// RUN     | iterating, or finishing a zero-divisor request on the next edge
module divu4_sequential
  import divu4_sequential_pkg::*;
#(
  parameter int WIDTH = DIVU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] rem_sh_q, rem_sh_d;
  logic [WIDTH-1:0] quo_sh_q, quo_sh_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             zero_q, zero_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dz_q, dz_d;

  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   trial;
  logic             carry;
  logic             no_borrow;

  assign r_shift = {rem_sh_q, quo_sh_q[WIDTH-1]};

  addsubn_unit #(.N(WIDTH + 1)) u_addsub (
    .subtract  (1'b1),
    .a         (r_shift),
    .b         ({1'b0, div_q}),
    .carry_in  (1'b1),
    .result    (trial),
    .carry_out (carry)
  );

  // Without a borrow the difference is below the divisor, so its top bit is always clear.
  assign no_borrow = carry & ~trial[WIDTH];

  always_comb begin
    state_d  = state_q;
    rem_sh_d = rem_sh_q;
    quo_sh_d = quo_sh_q;
    div_d    = div_q;
    cnt_d    = cnt_q;
    zero_d   = zero_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    quot_d   = quot_q;
    rem_d    = rem_q;
    dz_d     = dz_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          div_d    = divisor;
          quo_sh_d = dividend;
          rem_sh_d = '0;
          cnt_d    = '0;
          zero_d   = (divisor == '0);
          busy_d   = 1'b1;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (zero_q) begin
          quot_d  = {WIDTH{1'b1}};
          rem_d   = quo_sh_q;
          dz_d    = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          if (no_borrow) begin
            rem_sh_d = trial[WIDTH-1:0];
            quo_sh_d = {quo_sh_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_sh_d = r_shift[WIDTH-1:0];
            quo_sh_d = {quo_sh_q[WIDTH-2:0], 1'b0};
          end
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            quot_d  = quo_sh_d;
            rem_d   = rem_sh_d;
            dz_d    = 1'b0;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      rem_sh_q <= '0;
      quo_sh_q <= '0;
      div_q    <= '0;
      cnt_q    <= '0;
      zero_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      quot_q   <= '0;
      rem_q    <= '0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_sh_q <= rem_sh_d;
      quo_sh_q <= quo_sh_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      zero_q   <= zero_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      quot_q   <= quot_d;
      rem_q    <= rem_d;
      dz_q     <= dz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dz_q;

endmodule

// File: tb/tb_divu4_sequential.sv
// Scoreboard bench for divu4_sequential: driver pushes reference results, monitor checks on done.
module tb_divu4_sequential;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  divu4_sequential #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    int q;
    int r;
    int dz;
    int lat;
    int acc;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   failed = 0;
  int   cyc = 0;
  int   hold_q = 0, hold_r = 0, hold_dz = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: plain integer division with the zero-divisor convention.
  function automatic exp_t model(input int a, input int b, input int acc);
    exp_t e;
    if (b == 0) begin
      e.q = (1 << W) - 1; e.r = a; e.dz = 1; e.lat = 1;
    end else begin
      e.q = a / b; e.r = a % b; e.dz = 0; e.lat = W;
    end
    e.acc = acc;
    return e;
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("quotient", int'(quotient), e.q);
          chk("remainder", int'(remainder), e.r);
          chk("div_by_zero", int'(div_by_zero), e.dz);
          chk("latency", cyc - e.acc, e.lat);
          hold_q = e.q; hold_r = e.r; hold_dz = e.dz;
        end
      end else begin
        chk("hold_quotient", int'(quotient), hold_q);
        chk("hold_remainder", int'(remainder), hold_r);
        chk("hold_div_by_zero", int'(div_by_zero), hold_dz);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", 1, 0);
  endtask

  task automatic issue(input int a, input int b);
    wait_idle();
    start = 1'b1;
    dividend = W'(a);
    divisor = W'(b);
    sb.push_back(model(a, b, cyc + 1));
    @(negedge clk);
    start = 1'b0;
    dividend = W'($urandom);
    divisor = W'($urandom);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_quotient"}, int'(quotient), 0);
    chk({tag, "_remainder"}, int'(remainder), 0);
    chk({tag, "_dz"}, int'(div_by_zero), 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    @(negedge clk);

    issue(13, 3);
    issue(15, 1);
    issue(2, 5);
    issue(0, 7);
    issue(7, 0);
    issue(9, 2);

    // start while busy must be ignored
    issue(9, 2);
    @(negedge clk);
    chk("busy_before_ignored_start", int'(busy), 1);
    start = 1'b1; dividend = 4'd15; divisor = 4'd3;
    @(negedge clk);
    start = 1'b0;

    // back-to-back: second start lands in the done cycle of the first
    issue(13, 3);
    wait_idle();
    chk("done_at_back_to_back_start", int'(done), 1);
    issue(14, 4);

    // asynchronous reset in the middle of an operation
    wait_idle();
    start = 1'b1; dividend = 4'd11; divisor = 4'd2;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
    hold_q = 0; hold_r = 0; hold_dz = 0;
    @(negedge clk);
    check_reset_outputs("midop_reset");
    reset = 1'b0;
    repeat (W + 2) @(negedge clk);
    issue(11, 2);

    for (int a = 0; a < (1 << W); a++)
      for (int b = 0; b < (1 << W); b++)
        issue(a, b);

    for (int i = 0; i < 200; i++)
      issue(int'($urandom_range((1 << W) - 1, 0)), int'($urandom_range((1 << W) - 1, 0)));

    begin
      int n = 0;
      while (sb.size() != 0 && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk("scoreboard_drained", sb.size(), 0);
    end
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
